// File: rtl/output_mems_if.sv
// Bus bundle for output_mems: result-write port from compute plus the AXIS result stream.
interface output_mems_if #(
  parameter int unsigned OUTW = 32,
  parameter int unsigned AW   = 6
);
  logic [OUTW-1:0] C_wr_data;
  logic [AW-1:0]   C_wr_addr;
  logic            C_wr_en;
  logic            compute_finished;
  logic            C_mem_free;
  logic [OUTW-1:0] AXIS_TDATA;
  logic            AXIS_TVALID;
  logic            AXIS_TREADY;
  logic            AXIS_TLAST;
  logic            results_sent;

  // master: the output_mems side (sinks writes, drives the stream)
  modport master (
    input  C_wr_data, C_wr_addr, C_wr_en, compute_finished, AXIS_TREADY,
    output C_mem_free, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, results_sent
  );

  modport slave (
    output C_wr_data, C_wr_addr, C_wr_en, compute_finished, AXIS_TREADY,
    input  C_mem_free, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, results_sent
  );
endinterface

// File: rtl/output_mems.sv
// Result buffer for the matmul datapath: holds the M x N result and streams it out
// row-major over AXIS with a prefetch + one-entry holding register for full throughput.
module output_mems #(
  parameter int unsigned OUTW = 32,
  parameter int unsigned M    = 7,
  parameter int unsigned N    = 9
) (
  input  logic          clk,
  input  logic          reset,
  output_mems_if.master bus
);
  localparam int unsigned DEPTH       = M * N;
  localparam int unsigned C_ADDR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1);
  localparam int unsigned LAST        = DEPTH - 1;

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  logic [OUTW-1:0] mem [0:DEPTH-1];

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [C_ADDR_BITS-1:0] beat_q, beat_d;
  logic                   tvalid_q, tvalid_d;
  logic [OUTW-1:0]        tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic                   hold_v_q, hold_v_d;
  logic [OUTW-1:0]        hold_data_q, hold_data_d;
  logic                   mem_free_q, mem_free_d;
  logic                   sent_q, sent_d;
  logic [OUTW-1:0]        rd_data_q;

  logic                   pop_c;
  logic                   issue_c;
  logic                   wr_ok_c;
  logic [1:0]             occ_c;
  logic [C_ADDR_BITS-1:0] next_idx_c;
  logic [C_ADDR_BITS-1:0] rd_addr_c;

  assign pop_c      = tvalid_q & bus.AXIS_TREADY;
  assign wr_ok_c    = (state_q == IDLE) & bus.C_wr_en;
  assign rd_addr_c  = C_ADDR_BITS'(rd_cnt_q);
  // Words that will still be held (output + holding + in-flight read) after this cycle's pop
  assign occ_c      = 2'(tvalid_q) + 2'(hold_v_q) + 2'(rd_pend_q) - 2'(pop_c);
  assign next_idx_c = beat_q + C_ADDR_BITS'(pop_c);

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    beat_d      = beat_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    sent_d      = 1'b0;
    issue_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.compute_finished) state_d = FETCH;
      end
      FETCH: begin
        issue_c = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        // Only read ahead when the word is guaranteed a slot on arrival
        issue_c = (rd_cnt_q < CNT_W'(DEPTH)) && (occ_c < 2'd2);

        if (pop_c) begin
          if (beat_q == C_ADDR_BITS'(LAST)) begin
            beat_d  = '0;
            state_d = IDLE;
            sent_d  = 1'b1;
          end else begin
            beat_d = beat_q + C_ADDR_BITS'(1);
          end
        end

        if (!tvalid_q || pop_c) begin
          if (hold_v_q) begin
            tvalid_d    = 1'b1;
            tdata_d     = hold_data_q;
            tlast_d     = (next_idx_c == C_ADDR_BITS'(LAST));
            hold_v_d    = rd_pend_q;
            hold_data_d = rd_pend_q ? rd_data_q : hold_data_q;
          end else if (rd_pend_q) begin
            tvalid_d = 1'b1;
            tdata_d  = rd_data_q;
            tlast_d  = (next_idx_c == C_ADDR_BITS'(LAST));
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end else if (rd_pend_q) begin
          hold_v_d    = 1'b1;
          hold_data_d = rd_data_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_c) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if (state_d == IDLE) rd_cnt_d = '0;
    rd_pend_d  = issue_c;
    mem_free_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      rd_pend_q   <= 1'b0;
      beat_q      <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
      mem_free_q  <= 1'b1;
      sent_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_pend_q   <= rd_pend_d;
      beat_q      <= beat_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      mem_free_q  <= mem_free_d;
      sent_q      <= sent_d;
    end
  end

  // Result storage survives reset; read data is valid the cycle after issue
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[bus.C_wr_addr] <= bus.C_wr_data;
    if (issue_c) rd_data_q <= mem[rd_addr_c];
  end

  assign bus.C_mem_free   = mem_free_q;
  assign bus.AXIS_TDATA   = tdata_q;
  assign bus.AXIS_TVALID  = tvalid_q;
  assign bus.AXIS_TLAST   = tlast_q;
  assign bus.results_sent = sent_q;
endmodule
